// File: rtl/oled_glyph_writer.sv
// oled_glyph_writer: draws one font glyph onto an SSD1306-style page-addressed OLED.
// For each of the two pages the glyph covers, it sends a page command and two
// column commands, then W data bytes fetched from an external font ROM with a
// one-cycle read latency.
module oled_glyph_writer (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_font_sel,
  input  logic       req_wide,
  input  logic [2:0] req_page,
  input  logic [6:0] req_col,
  output logic [5:0] font_sel,
  output logic       font_row,
  output logic [8:0] index,
  input  logic [7:0] font_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_dc,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, CMD_PAGE, CMD_COLL, CMD_COLH, FETCH, LATCH, SEND, DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] page_reg, page_next;
  logic [6:0] col_reg, col_next;
  logic       wide_reg, wide_next;
  logic       row_reg, row_next;
  logic [3:0] idx_reg, idx_next;
  logic [5:0] sel_reg, sel_next;
  logic [7:0] byte_reg, byte_next;
  logic       dc_reg, dc_next;
  logic [3:0] last_idx;

  // Index of the final data byte in a row: 7 for ASCII, 15 for CJK.
  assign last_idx = wide_reg ? 4'd15 : 4'd7;

  // ROM address and transmit byte come straight from registers so they stay
  // stable across ROM latency and transmitter stalls.
  assign font_sel = sel_reg;
  assign font_row = row_reg;
  assign index    = {5'd0, idx_reg};
  assign tx_byte  = byte_reg;
  assign tx_dc    = dc_reg;

  // State and datapath registers; async reset returns everything to idle zeros.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      page_reg  <= 3'd0;
      col_reg   <= 7'd0;
      wide_reg  <= 1'b0;
      row_reg   <= 1'b0;
      idx_reg   <= 4'd0;
      sel_reg   <= 6'd0;
      byte_reg  <= 8'h00;
      dc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      page_reg  <= page_next;
      col_reg   <= col_next;
      wide_reg  <= wide_next;
      row_reg   <= row_next;
      idx_reg   <= idx_next;
      sel_reg   <= sel_next;
      byte_reg  <= byte_next;
      dc_reg    <= dc_next;
    end
  end

  // Next-state logic; each outgoing byte is loaded on the edge that enters its
  // state, so tx_byte/tx_dc only change after a transfer has completed.
  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    col_next   = col_reg;
    wide_next  = wide_reg;
    row_next   = row_reg;
    idx_next   = idx_reg;
    sel_next   = sel_reg;
    byte_next  = byte_reg;
    dc_next    = dc_reg;
    req_ready  = 1'b0;
    tx_valid   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          sel_next   = req_font_sel;
          wide_next  = req_wide;
          page_next  = req_page;
          col_next   = req_col;
          row_next   = 1'b0;
          idx_next   = 4'd0;
          byte_next  = {5'b10110, req_page};
          dc_next    = 1'b0;
          state_next = CMD_PAGE;
        end
      end
      CMD_PAGE: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          byte_next  = {4'h0, col_reg[3:0]};
          state_next = CMD_COLL;
        end
      end
      CMD_COLL: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          byte_next  = {5'b00010, col_reg[6:4]};
          state_next = CMD_COLH;
        end
      end
      CMD_COLH: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          idx_next   = 4'd0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = LATCH;
      end
      LATCH: begin
        byte_next  = font_data;
        dc_next    = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (idx_reg == last_idx) begin
            if (row_reg) begin
              state_next = DONE;
            end else begin
              // Bottom page wraps within 3 bits; column commands repeat unchanged.
              row_next   = 1'b1;
              byte_next  = {5'b10110, page_reg + 3'd1};
              dc_next    = 1'b0;
              state_next = CMD_PAGE;
            end
          end else begin
            idx_next   = idx_reg + 4'd1;
            state_next = FETCH;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
